pixel_packer_wr: RTL
====================

// Module: pixel_packer_wr
// PURPOSE
//  Write-side stage feeding fifo_dc. Packs a pixel stream (wr_clock domain) into
//  PACK_NUM-pixel words, drives fifo_dc wr_en/wr_data, and tracks FIFO occupancy
//  with a credit counter, so the FIFO is never overwritten. Read-side consumption
//  is signalled by a toggle from the rd_clock domain, synchronised internally.
// PARAMETERS
//  PIXEL_BITW = 8    : bits per pixel
//  PACK_NUM   = 4    : pixels per FIFO word (>=1)
//  FIFO_SIZE  = 1024 : depth of downstream fifo_dc in words; must match its FIFO_SIZE
// PORTS
//  wr_clock      in   1                    : clock
//  n_rst         in   1                    : reset, synchronous, active-low
//  in_flag       in   1                    : pixel valid
//  in_data       in   PIXEL_BITW           : pixel
//  in_sof        in   1                    : first pixel of frame (qualified by in_flag)
//  in_eol        in   1                    : last pixel of line (qualified by in_flag)
//  rd_toggle     in   1                    : rd_clock domain; toggles once per word read
//  out_wr_en     out  1                    : to fifo_dc wr_en
//  out_wr_data   out  PIXEL_BITW*PACK_NUM  : to fifo_dc wr_data
//  out_level     out  $clog2(FIFO_SIZE+1)  : words in FIFO (credit view)
//  out_full      out  1                    : out_level == FIFO_SIZE
//  out_overflow  out  1                    : sticky, a word was dropped
// BEHAVIOUR
//  Reset: state WAIT_SOF, lane index 0, out_wr_en 0, out_wr_data 0, out_level 0,
//   out_full 0, out_overflow 0, sync regs 0 (rd_toggle must be 0 at reset on both sides).
//  FSM: WAIT_SOF - pixels without in_sof ignored; in_flag&in_sof -> PACK, pixel accepted.
//   PACK - accept pixels; emit on word complete or in_eol.
//   DROP_LINE - discard pixels; in_flag&in_eol -> PACK (eol pixel discarded);
//   in_flag&in_sof -> PACK with that pixel accepted.
//  in_sof in any state: partial word discarded, lane index 0, out_overflow cleared,
//   sof pixel goes to lane 0.
//  Packing: first pixel of a word in bits [PIXEL_BITW-1:0] (lane 0), ascending lanes.
//  Emit: pixel filling lane PACK_NUM-1, or any pixel with in_eol -> out_wr_en=1 with
//   word on the next cycle (latency 1); unused lanes on eol-partial word are 0.
//   out_wr_data holds last value when out_wr_en=0. Lane index returns to 0 after emit.
//  Full at emit time (level==FIFO_SIZE before this cycle's credit): word dropped,
//   out_wr_en stays 0, out_overflow<=1; if word did not end on eol -> DROP_LINE,
//   else stay PACK (line alignment preserved).
//  Credit: rd_toggle -> 2-FF sync -> edge detect (3rd FF) = 1-cycle credit pulse;
//   rd_toggle edge to level decrement: 3 cycles.
//  Level: write only +1, credit only -1, both same cycle unchanged; credit at 0 ignored
//   (no underflow). Credit arriving same cycle as full-check does not rescue the word.
//  out_full/out_level registered, updated the cycle after the event.
//  in_flag=0 cycles: no state change; partial word held indefinitely.
// CONFIGURATION
//  PACKER_LINE_COUNT_EN defined: extra port out_line_cnt out 16 - lines completed
//   (in_eol accepted in PACK, word written or dropped) since last in_sof; reset 0,
//   in_sof clears to 0 (sof pixel with eol counts 1), wraps 0xFFFF->0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1) PACK_NUM=4, sof + pixels 01..08 continuous -> two writes 0x04030201, 0x08070605,
//     each 1 cycle after 4th/8th pixel; out_level 2.
//  2) Line of 6 pixels 11..16, eol on 16 -> writes 0x14131211 then 0x00001615.
//  3) FIFO_SIZE=4, no toggles, 5 words sent -> 4 writes, out_full=1, 5th dropped,
//     out_overflow=1, DROP_LINE until eol; next line written once credits arrive.
//  4) rd_toggle flips once per cycle while writes continue -> out_level constant
//     after 3-cycle lag; toggles at level 0 -> level stays 0.
//  5) Pixels before sof ignored; sof mid-word with 2 lanes filled -> partial discarded,
//     next word starts with sof pixel in lane 0, out_overflow cleared.
//  6) n_rst low mid-line -> next cycle all outputs reset values, WAIT_SOF;
//     with PACKER_LINE_COUNT_EN, 3 eol lines -> out_line_cnt 3, sof -> 0.

Source files
------------

// File: rtl/pixel_packer_wr_if.sv
// rtl/pixel_packer_wr_if.sv - pixel stream in / fifo_dc write port out for pixel_packer_wr
interface pixel_packer_wr_if #(
    parameter int PIXEL_BITW = 8,
    parameter int PACK_NUM   = 4
);
    logic                           in_flag;
    logic [PIXEL_BITW-1:0]          in_data;
    logic                           in_sof;
    logic                           in_eol;
    logic                           out_wr_en;
    logic [PIXEL_BITW*PACK_NUM-1:0] out_wr_data;

    modport master (
        output in_flag, in_data, in_sof, in_eol,
        input  out_wr_en, out_wr_data
    );

    modport slave (
        input  in_flag, in_data, in_sof, in_eol,
        output out_wr_en, out_wr_data
    );
endinterface

// File: rtl/pixel_packer_wr.sv
// rtl/pixel_packer_wr.sv - packs pixels into fifo_dc words with credit-based occupancy tracking
// Optional line counter port out_line_cnt enabled by defining PACKER_LINE_COUNT_EN.
module pixel_packer_wr #(
    parameter int PIXEL_BITW = 8,
    parameter int PACK_NUM   = 4,
    parameter int FIFO_SIZE  = 1024
) (
    input  logic                           wr_clock,
    input  logic                           n_rst,
    pixel_packer_wr_if.slave               pix,
    input  logic                           rd_toggle,
    output logic [$clog2(FIFO_SIZE+1)-1:0] out_level,
    output logic                           out_full,
`ifdef PACKER_LINE_COUNT_EN
    output logic                           out_overflow,
    output logic [15:0]                    out_line_cnt
`else
    output logic                           out_overflow
`endif
);
    localparam int WORD_W = PIXEL_BITW * PACK_NUM;
    localparam int LVL_W  = $clog2(FIFO_SIZE + 1);
    localparam int LANE_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_NUM - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(FIFO_SIZE);

    typedef enum logic [1:0] {WAIT_SOF, PACK, DROP_LINE} state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d, lane_pos;
    logic [WORD_W-1:0]   word_q, word_d, base_word, new_word;
    logic                wr_en_q, wr_en_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                sync1_q, sync2_q, sync3_q;
    logic                accept, credit, dec;

    // rd_toggle crosses domains: two FFs to settle, third for edge detect.
    assign credit = sync2_q ^ sync3_q;
    assign accept = pix.in_flag && (pix.in_sof || state_q == PACK);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        lane_pos  = lane_q;
        base_word = word_q;
        if (pix.in_flag && pix.in_sof) begin
            lane_pos  = '0;
            base_word = '0;
            ovf_d     = 1'b0;
            state_d   = PACK;
        end
        new_word = base_word;
        new_word[int'(lane_pos)*PIXEL_BITW +: PIXEL_BITW] = pix.in_data;
        if (accept) begin
            if (lane_pos == LAST_LANE || pix.in_eol) begin
                lane_d = '0;
                word_d = '0;
                if (full_q) begin
                    // Keep line alignment: a word cut by eol needs no resync.
                    ovf_d   = 1'b1;
                    state_d = pix.in_eol ? PACK : DROP_LINE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = new_word;
                end
            end else begin
                lane_d = lane_pos + 1'b1;
                word_d = new_word;
            end
        end else if (state_q == DROP_LINE && pix.in_flag && pix.in_eol) begin
            state_d = PACK;
        end
    end

    // A credit with nothing counted is spurious and is ignored.
    assign dec = credit && (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (wr_en_d && !dec)
            level_d = level_q + 1'b1;
        else if (dec && !wr_en_d)
            level_d = level_q - 1'b1;
        full_d = (level_d == LVL_MAX);
    end

    always_ff @(posedge wr_clock) begin
        if (!n_rst) begin
            state_q   <= WAIT_SOF;
            lane_q    <= '0;
            word_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            level_q   <= level_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            sync1_q   <= rd_toggle;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
        end
    end

    assign pix.out_wr_en   = wr_en_q;
    assign pix.out_wr_data = wr_data_q;
    assign out_level       = level_q;
    assign out_full        = full_q;
    assign out_overflow    = ovf_q;

`ifdef PACKER_LINE_COUNT_EN
    logic [15:0] line_cnt_q, line_cnt_d;

    // An sof pixel restarts the count, and still counts itself if it carries eol.
    always_comb begin
        line_cnt_d = line_cnt_q;
        if (accept)
            line_cnt_d = (pix.in_sof ? 16'd0 : line_cnt_q) + {15'd0, pix.in_eol};
    end

    always_ff @(posedge wr_clock) begin
        if (!n_rst)
            line_cnt_q <= '0;
        else
            line_cnt_q <= line_cnt_d;
    end

    assign out_line_cnt = line_cnt_q;
`endif
endmodule
